// File: rtl/ysyx_24090003_ctrl_pkg.sv
// Shared encodings for the NPC multi-cycle sequencer: FSM states, memory
// classes and default parameter values.
package ysyx_24090003_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_MEM    = ST_MEM,
    S_WB     = ST_WB,
    S_HALT   = ST_HALT,
    S_ERR    = ST_ERR
  } state_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h8000_0000;
  localparam int          DEFAULT_WAIT_LIMIT = 255;

  // Encoding 11 is reserved and behaves like "no memory access".
  function automatic logic is_mem_access(input logic [1:0] op);
    return (op == MEM_LOAD) || (op == MEM_STORE);
  endfunction

endpackage

// File: rtl/ysyx_24090003_seq_ctrl_if.sv
// Handshake and status bundle between the sequencer (master) and the
// IFU/IDU/EXU/LSU side of the core (slave).
interface ysyx_24090003_seq_ctrl_if;

  logic        ifetch_req;
  logic        ifetch_valid;
  logic [31:0] ifetch_inst;
  logic [31:0] inst_q;
  logic        idu_en;
  logic [1:0]  mem_op;
  logic        is_ebreak;
  logic        exu_en;
  logic        dmem_req;
  logic        dmem_ack;
  logic        npc_write_enable;
  logic [31:0] EXnpc;
  logic        reg_write_enable;
  logic        rf_commit;
  logic [31:0] pc;
  logic [31:0] retire_cnt;
  logic        halted;
  logic        err;

  modport master (
    output ifetch_req, inst_q, idu_en, exu_en, dmem_req, rf_commit,
           pc, retire_cnt, halted, err,
    input  ifetch_valid, ifetch_inst, mem_op, is_ebreak, dmem_ack,
           npc_write_enable, EXnpc, reg_write_enable
  );

  modport slave (
    input  ifetch_req, inst_q, idu_en, exu_en, dmem_req, rf_commit,
           pc, retire_cnt, halted, err,
    output ifetch_valid, ifetch_inst, mem_op, is_ebreak, dmem_ack,
           npc_write_enable, EXnpc, reg_write_enable
  );

endinterface

// File: rtl/ysyx_24090003_wait_timer.sv
// 8-bit wait counter: cleared while idle, counts stalled cycles, and flags
// expiry combinationally in the cycle that would reach the limit.
module ysyx_24090003_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= 8'd0;
    end else if (count_en) begin
      count <= count + 8'd1;
    end
  end

  assign expire = count_en && (count == LAST);

endmodule

// File: rtl/ysyx_24090003_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns the PC, steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB and stops on ebreak, timeout or bad PC.
module ysyx_24090003_seq_ctrl
  import ysyx_24090003_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_rst,
  ysyx_24090003_seq_ctrl_if.master  bus
);

  state_t      state;
  logic [1:0]  mem_op_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] retire_q;
  logic        halted_q;
  logic        err_q;
  logic        ifetch_req_q;
  logic        idu_en_q;
  logic        exu_en_q;
  logic        dmem_req_q;

  logic        waiting;
  logic        awaited;
  logic        timeout;
  logic [31:0] next_pc;
  logic        next_pc_bad;

  assign waiting     = (state == S_FETCH) || (state == S_MEM);
  assign awaited     = (state == S_FETCH) ? bus.ifetch_valid : bus.dmem_ack;
  assign next_pc     = bus.npc_write_enable ? bus.EXnpc : (pc_q + 32'd4);
  assign next_pc_bad = |next_pc[1:0];

  // Counter idles at zero outside FETCH/MEM, so every entry starts fresh.
  ysyx_24090003_wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk      (cpu_clk),
    .rst      (cpu_rst),
    .clear    (!waiting),
    .count_en (waiting && !awaited),
    .expire   (timeout)
  );

  // Strobes are registered against the state being entered, so they are
  // high exactly while the FSM sits in the matching state.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state        <= S_IDLE;
      mem_op_q     <= MEM_NONE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      retire_q     <= 32'd0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
      ifetch_req_q <= 1'b0;
      idu_en_q     <= 1'b0;
      exu_en_q     <= 1'b0;
      dmem_req_q   <= 1'b0;
    end else begin
      ifetch_req_q <= 1'b0;
      idu_en_q     <= 1'b0;
      exu_en_q     <= 1'b0;
      dmem_req_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          state        <= S_FETCH;
          ifetch_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (bus.ifetch_valid) begin
            inst_q   <= bus.ifetch_inst;
            state    <= S_DECODE;
            idu_en_q <= 1'b1;
          end else if (timeout) begin
            err_q <= 1'b1;
            state <= S_ERR;
          end else begin
            ifetch_req_q <= 1'b1;
          end
        end
        S_DECODE: begin
          mem_op_q <= bus.mem_op;
          if (bus.is_ebreak) begin
            halted_q <= 1'b1;
            state    <= S_HALT;
          end else begin
            state    <= S_EXEC;
            exu_en_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (is_mem_access(mem_op_q)) begin
            state      <= S_MEM;
            dmem_req_q <= 1'b1;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            state <= S_WB;
          end else if (timeout) begin
            err_q <= 1'b1;
            state <= S_ERR;
          end else begin
            dmem_req_q <= 1'b1;
          end
        end
        S_WB: begin
          if (next_pc_bad) begin
            err_q <= 1'b1;
            state <= S_ERR;
          end else begin
            pc_q         <= next_pc;
            retire_q     <= retire_q + 32'd1;
            state        <= S_FETCH;
            ifetch_req_q <= 1'b1;
          end
        end
        S_HALT:  state <= S_HALT;
        S_ERR:   state <= S_ERR;
        default: state <= S_ERR;
      endcase
    end
  end

  assign bus.ifetch_req = ifetch_req_q;
  assign bus.idu_en     = idu_en_q;
  assign bus.exu_en     = exu_en_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.rf_commit  = (state == S_WB) && bus.reg_write_enable;
  assign bus.inst_q     = inst_q;
  assign bus.pc         = pc_q;
  assign bus.retire_cnt = retire_q;
  assign bus.halted     = halted_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_ysyx_24090003_seq_ctrl.sv
// Directed self-checking bench for the NPC sequencer with hand-computed
// expectations for pipeline cadence, memory waits, redirects and stops.
module tb_ysyx_24090003_seq_ctrl;
  import ysyx_24090003_ctrl_pkg::*;

  localparam logic [31:0] PC0  = 32'h8000_0000;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] LW   = 32'h0000_2103;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cnt_a;
  int   cnt_b;
  int   cyc;

  ysyx_24090003_seq_ctrl_if bus();

  ysyx_24090003_seq_ctrl #(
    .RESET_PC   (PC0),
    .WAIT_LIMIT (255)
  ) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Sample point sits 1 time unit after each rising edge.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic check_reset_state(input string p);
    check_output({p, "_pc"},     bus.pc,         PC0);
    check_output({p, "_retire"}, bus.retire_cnt, 32'd0);
    check_output({p, "_inst"},   bus.inst_q,     32'd0);
    check_output({p, "_halted"}, 32'(bus.halted),     32'd0);
    check_output({p, "_err"},    32'(bus.err),        32'd0);
    check_output({p, "_ifreq"},  32'(bus.ifetch_req), 32'd0);
    check_output({p, "_idu"},    32'(bus.idu_en),     32'd0);
    check_output({p, "_exu"},    32'(bus.exu_en),     32'd0);
    check_output({p, "_dreq"},   32'(bus.dmem_req),   32'd0);
    check_output({p, "_commit"}, 32'(bus.rf_commit),  32'd0);
  endtask

  initial begin
    bus.ifetch_valid     = 1'b0;
    bus.ifetch_inst      = ADDI;
    bus.mem_op           = MEM_NONE;
    bus.is_ebreak        = 1'b0;
    bus.dmem_ack         = 1'b0;
    bus.npc_write_enable = 1'b0;
    bus.EXnpc            = 32'd0;
    bus.reg_write_enable = 1'b1;

    tick_n(2);
    check_reset_state("rst0");

    // Straight-line addi stream: FETCH/DECODE/EXEC/WB repeating.
    bus.ifetch_valid = 1'b1;
    cpu_rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_output($sformatf("seq%0d_ifreq", k), 32'(bus.ifetch_req), 32'((k % 4) == 0));
      check_output($sformatf("seq%0d_idu", k),   32'(bus.idu_en),     32'((k % 4) == 1));
      check_output($sformatf("seq%0d_exu", k),   32'(bus.exu_en),     32'((k % 4) == 2));
      check_output($sformatf("seq%0d_commit", k), 32'(bus.rf_commit), 32'((k % 4) == 3));
      check_output($sformatf("seq%0d_pc", k),    bus.pc,         PC0 + 32'(4 * (k / 4)));
      check_output($sformatf("seq%0d_retire", k), bus.retire_cnt, 32'(k / 4));
    end
    tick();
    check_output("seq_pc3",     bus.pc,         32'h8000_000C);
    check_output("seq_retire3", bus.retire_cnt, 32'd3);
    check_output("seq_inst",    bus.inst_q,     ADDI);

    // Load whose ack arrives on the 4th request cycle.
    bus.mem_op      = MEM_LOAD;
    bus.ifetch_inst = LW;
    cnt_a = 0;
    cnt_b = 0;
    cyc   = 0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (bus.dmem_req) cnt_a++;
      if (bus.rf_commit) cnt_b++;
      bus.dmem_ack = bus.dmem_req && (cnt_a == 4);
      if (bus.ifetch_req) break;
    end
    bus.dmem_ack = 1'b0;
    bus.mem_op   = MEM_NONE;
    check_output("ld_cycles",  32'(cyc),   32'd8);
    check_output("ld_dreq",    32'(cnt_a), 32'd4);
    check_output("ld_commit",  32'(cnt_b), 32'd1);
    check_output("ld_pc",      bus.pc,         32'h8000_0010);
    check_output("ld_retire",  bus.retire_cnt, 32'd4);
    check_output("ld_inst",    bus.inst_q,     LW);

    // Redirect to an aligned target, then to a misaligned one.
    bus.ifetch_inst      = ADDI;
    bus.npc_write_enable = 1'b1;
    bus.EXnpc            = 32'h8000_0100;
    tick_n(4);
    check_output("jmp_ifreq",  32'(bus.ifetch_req), 32'd1);
    check_output("jmp_pc",     bus.pc,         32'h8000_0100);
    check_output("jmp_retire", bus.retire_cnt, 32'd5);
    bus.EXnpc = 32'h8000_0102;
    tick_n(4);
    check_output("mis_err",    32'(bus.err),        32'd1);
    check_output("mis_pc",     bus.pc,              32'h8000_0100);
    check_output("mis_retire", bus.retire_cnt,      32'd5);
    check_output("mis_ifreq",  32'(bus.ifetch_req), 32'd0);
    cnt_a = 0;
    repeat (6) begin
      tick();
      if (bus.ifetch_req || bus.dmem_req) cnt_a++;
    end
    check_output("mis_noreq", 32'(cnt_a), 32'd0);
    check_output("mis_stick", 32'(bus.err), 32'd1);

    // Fetch timeout after 255 stalled cycles.
    bus.npc_write_enable = 1'b0;
    bus.ifetch_valid     = 1'b0;
    cpu_rst = 1'b1;
    tick();
    check_reset_state("rst1");
    cpu_rst = 1'b0;
    tick();
    tick_n(254);
    check_output("to255_ifreq", 32'(bus.ifetch_req), 32'd1);
    check_output("to255_err",   32'(bus.err),        32'd0);
    tick();
    check_output("to_err",   32'(bus.err),        32'd1);
    check_output("to_ifreq", 32'(bus.ifetch_req), 32'd0);

    // Valid on the 255th stalled cycle wins over the timeout.
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    tick();
    tick_n(254);
    bus.ifetch_valid = 1'b1;
    tick();
    check_output("late_idu",  32'(bus.idu_en), 32'd1);
    check_output("late_err",  32'(bus.err),    32'd0);
    check_output("late_inst", bus.inst_q,      ADDI);

    // One addi retires, then ebreak halts the core.
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    tick_n(5);
    check_output("eb_pre_retire", bus.retire_cnt, 32'd1);
    bus.is_ebreak = 1'b1;
    tick();
    check_output("eb_idu", 32'(bus.idu_en), 32'd1);
    tick();
    check_output("eb_halted", 32'(bus.halted), 32'd1);
    check_output("eb_retire", bus.retire_cnt,  32'd1);
    check_output("eb_pc",     bus.pc,          32'h8000_0004);
    cnt_a = 0;
    cnt_b = 0;
    repeat (6) begin
      if (bus.exu_en) cnt_a++;
      if (bus.ifetch_req || bus.idu_en || bus.dmem_req) cnt_b++;
      tick();
    end
    check_output("eb_noexu",   32'(cnt_a), 32'd0);
    check_output("eb_nostrobe", 32'(cnt_b), 32'd0);
    check_output("eb_stick",   32'(bus.halted), 32'd1);
    bus.is_ebreak = 1'b0;
    cpu_rst = 1'b1;
    tick();
    check_reset_state("rst2");

    // Reset during MEM with an ack in the reset cycle abandons the load.
    cpu_rst = 1'b0;
    tick_n(5);
    bus.mem_op = MEM_LOAD;
    tick_n(3);
    check_output("mr_dreq",   32'(bus.dmem_req), 32'd1);
    check_output("mr_retire", bus.retire_cnt,    32'd1);
    cpu_rst      = 1'b1;
    bus.dmem_ack = 1'b1;
    tick();
    check_reset_state("rst3");
    cpu_rst      = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.mem_op   = MEM_NONE;
    tick();
    check_output("mr_refetch", 32'(bus.ifetch_req), 32'd1);
    check_output("mr_pc",      bus.pc,              PC0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_24090003_seq_ctrl.md
# ysyx_24090003_seq_ctrl

Multi-cycle instruction sequencer for the NPC core. It steps each instruction through fetch, decode, execute, optional memory access and write-back, and issues one-cycle enable strobes to the IDU and EXU stages. It owns the architectural PC, gates register-file commit and counts retired instructions. It also stops the core on `ebreak`, on a memory-wait timeout, or on a misaligned next PC.

## Interface
Parameters:
- `RESET_PC`, `32'h8000_0000`, PC value loaded on reset.
- `WAIT_LIMIT`, `255`, maximum wait cycles tolerated in FETCH or MEM before the error state is entered (8-bit counter).

Ports:
- `cpu_clk` in 1: single clock; all state changes on its rising edge.
- `cpu_rst` in 1: reset, synchronous, active-high.
- `ifetch_req` out 1: instruction fetch request; address is `pc`.
- `ifetch_valid` in 1: fetch data valid this cycle.
- `ifetch_inst` in 32: fetched instruction.
- `inst_q` out 32: latched instruction, stable from DECODE to the end of WB.
- `idu_en` out 1: decode strobe.
- `mem_op` in 2: decoded memory class (00 none, 01 load, 10 store, 11 treated as none); sampled in DECODE.
- `is_ebreak` in 1: decoded `ebreak`; sampled in DECODE.
- `exu_en` out 1: execute strobe; the EXU registers its results on this edge.
- `dmem_req` out 1: data-memory request.
- `dmem_ack` in 1: data-memory completion.
- `npc_write_enable` in 1: EXU redirect flag; sampled in WB.
- `EXnpc` in 32: EXU redirect target; sampled in WB.
- `reg_write_enable` in 1: EXU register-write request.
- `rf_commit` out 1: register-file write enable; equals `reg_write_enable` in WB, otherwise 0.
- `pc` out 32: architectural PC.
- `retire_cnt` out 32: retired-instruction counter.
- `halted` out 1: sticky; set on `ebreak`.
- `err` out 1: sticky; set on timeout or misaligned next PC.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
- IDLE: entered on reset. Moves to FETCH unconditionally on the next cycle.
- FETCH:
  - `ifetch_req`=1 for the whole state.
  - `ifetch_valid`=1, including on the first FETCH cycle: latch `inst_q`, go to DECODE.
- DECODE:
  - `idu_en`=1 for one cycle; latch `mem_op`.
  - `is_ebreak`=1: go to HALT, set `halted`.
  - Otherwise go to EXEC.
- EXEC: `exu_en`=1 for one cycle. Next state is MEM if the latched `mem_op` is 01 or 10, otherwise WB.
- MEM: `dmem_req`=1 until `dmem_ack`; on ack go to WB.
- WB:
  - `rf_commit`=`reg_write_enable`.
  - Next PC is `EXnpc` if `npc_write_enable`, else `pc`+4; 32-bit add with wrap at 2^32.
  - Next PC bits [1:0] non-zero: set `err`, go to ERR, leave PC unchanged, do not increment `retire_cnt`.
  - Otherwise load PC, increment `retire_cnt` (wraps at 2^32), go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH and to MEM; increments each cycle the awaited signal is low.
  - Reaching `WAIT_LIMIT` without the awaited signal: set `err`, go to ERR.
  - Valid or ack arriving in the same cycle the counter reaches the limit wins; no error.
- HALT and ERR are terminal until `cpu_rst`. All strobes are 0 in these states.
- `rf_commit` is 0 in every state except WB.

## Timing
- Reset values:
  - state IDLE, `pc`=`RESET_PC`, `inst_q`=0, `retire_cnt`=0, `halted`=0, `err`=0.
  - `ifetch_req`, `idu_en`, `exu_en`, `dmem_req`, `rf_commit` all 0.
- All outputs are Moore outputs (decoded from state), except `rf_commit`, which is combinational from `reg_write_enable` in WB.
- Latency, zero-wait memory:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
- First fetch request appears 1 cycle after reset deasserts.
- `cpu_rst` asserted mid-instruction: abandons it at the next edge.
  - All requests drop, no commit occurs, `pc` returns to `RESET_PC`.
  - A `dmem_ack` arriving in the reset cycle is ignored.
- Request signals stay asserted until acknowledged; they are never withdrawn except by reset or timeout.

## Structure
- Package `ysyx_24090003_ctrl_pkg` holds:
  - the state encoding (localparams, 3-bit);
  - the `mem_op` encodings;
  - the default `RESET_PC`.
- One sub-module: `ysyx_24090003_wait_timer`, the 8-bit clear/count/expire counter used in FETCH and MEM.

## Test plan
- Reset, then `ifetch_valid` held 1 with `addi` encoding, `mem_op`=00, `npc_write_enable`=0 -> `pc` 0x8000_0000, 0x8000_0004, 0x8000_0008 at 4-cycle spacing; `retire_cnt`=3 after 12 cycles.
- Load with `dmem_ack` delayed 3 cycles -> `dmem_req` high exactly 4 cycles; `rf_commit` pulses once in WB; instruction takes 8 cycles.
- `npc_write_enable`=1, `EXnpc`=0x8000_0100 -> next `ifetch_req` shows `pc`=0x8000_0100. With `EXnpc`=0x8000_0102 instead -> `err`=1, `pc` unchanged, no further requests.
- `ifetch_valid` held 0 for 255 cycles -> `err`=1. Same case with valid arriving on cycle 255 -> no error; DECODE follows.
- `is_ebreak`=1 in DECODE -> `halted`=1, `exu_en` never pulses, `retire_cnt` unchanged. Then `cpu_rst` -> all outputs return to reset values.
